// File: rtl/alu_op_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_op_sequencer: single-outstanding command dispatcher to four ALU units
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int IN_DATA_WIDTH = 16,
    parameter int OUT_WIDTH     = 16,
    parameter int TIMEOUT       = 8
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     Cmd_Valid,
    output logic                     Cmd_Ready,
    input  logic [3:0]               Cmd_Op,
    input  logic [IN_DATA_WIDTH-1:0] Cmd_A,
    input  logic [IN_DATA_WIDTH-1:0] Cmd_B,
    output logic [IN_DATA_WIDTH-1:0] A,
    output logic [IN_DATA_WIDTH-1:0] B,
    output logic [1:0]               ALU_FUN,
    output logic                     Arith_Enable,
    output logic                     Logic_Enable,
    output logic                     CMP_Enable,
    output logic                     Shift_Enable,
    input  logic [OUT_WIDTH-1:0]     Arith_OUT,
    input  logic [OUT_WIDTH-1:0]     Logic_OUT,
    input  logic [OUT_WIDTH-1:0]     CMP_OUT,
    input  logic [OUT_WIDTH-1:0]     Shift_OUT,
    input  logic                     Arith_Flag,
    input  logic                     Logic_Flag,
    input  logic                     CMP_Flag,
    input  logic                     Shift_Flag,
    output logic                     Res_Valid,
    input  logic                     Res_Ready,
    output logic [OUT_WIDTH-1:0]     Res_Data,
    output logic [1:0]               Res_Unit,
    output logic                     Res_Err
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IN_DATA_WIDTH-1:0] a_q, a_d;
    logic [IN_DATA_WIDTH-1:0] b_q, b_d;
    logic [1:0]               fun_q, fun_d;
    logic [1:0]               sel_q, sel_d;
    logic [3:0]               en_q, en_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     res_valid_q, res_valid_d;
    logic [OUT_WIDTH-1:0]     res_data_q, res_data_d;
    logic [1:0]               res_unit_q, res_unit_d;
    logic                     res_err_q, res_err_d;

    logic                     sel_flag;
    logic [OUT_WIDTH-1:0]     sel_out;
    logic                     cmd_ready;

    assign cmd_ready = (state_q == S_IDLE) && rst;

    // Only the unit that was dispatched is ever looked at.
    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (sel_q)
            2'b00:   begin sel_flag = Arith_Flag; sel_out = Arith_OUT; end
            2'b01:   begin sel_flag = Logic_Flag; sel_out = Logic_OUT; end
            2'b10:   begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
            default: begin sel_flag = Shift_Flag; sel_out = Shift_OUT; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        sel_d       = sel_q;
        en_d        = en_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_unit_d  = res_unit_q;
        res_err_d   = res_err_q;

        case (state_q)
            S_IDLE: begin
                if (Cmd_Valid && cmd_ready) begin
                    a_d     = Cmd_A;
                    b_d     = Cmd_B;
                    fun_d   = Cmd_Op[1:0];
                    sel_d   = Cmd_Op[3:2];
                    en_d    = 4'b0001 << Cmd_Op[3:2];
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A flag arriving on the final cycle still beats the timeout.
                if (sel_flag) begin
                    res_data_d  = sel_out;
                    res_unit_d  = sel_q;
                    res_err_d   = 1'b0;
                    en_d        = 4'b0000;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    res_data_d  = '0;
                    res_unit_d  = sel_q;
                    res_err_d   = 1'b1;
                    en_d        = 4'b0000;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (Res_Ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                en_d        = 4'b0000;
                res_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= 2'b00;
            sel_q       <= 2'b00;
            en_q        <= 4'b0000;
            cnt_q       <= 8'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_unit_q  <= 2'b00;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_unit_q  <= res_unit_d;
            res_err_q   <= res_err_d;
        end
    end

    assign Cmd_Ready    = cmd_ready;
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q;
    assign Arith_Enable = en_q[0];
    assign Logic_Enable = en_q[1];
    assign CMP_Enable   = en_q[2];
    assign Shift_Enable = en_q[3];
    assign Res_Valid    = res_valid_q;
    assign Res_Data     = res_data_q;
    assign Res_Unit     = res_unit_q;
    assign Res_Err      = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_alu_op_sequencer: directed self-checking bench with simple unit models
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic        CLK;
    logic        rst;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [3:0]  Cmd_Op;
    logic [15:0] Cmd_A, Cmd_B;
    logic [15:0] A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic        Res_Valid;
    logic        Res_Ready;
    logic [15:0] Res_Data;
    logic [1:0]  Res_Unit;
    logic        Res_Err;

    logic [3:0]  en_vec;
    logic [3:0]  fl_q;
    logic [3:0]  auto_flag;
    logic [3:0]  force_flag;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(
        .IN_DATA_WIDTH(16),
        .OUT_WIDTH    (16),
        .TIMEOUT      (8)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .Cmd_Valid   (Cmd_Valid),
        .Cmd_Ready   (Cmd_Ready),
        .Cmd_Op      (Cmd_Op),
        .Cmd_A       (Cmd_A),
        .Cmd_B       (Cmd_B),
        .A           (A),
        .B           (B),
        .ALU_FUN     (ALU_FUN),
        .Arith_Enable(Arith_Enable),
        .Logic_Enable(Logic_Enable),
        .CMP_Enable  (CMP_Enable),
        .Shift_Enable(Shift_Enable),
        .Arith_OUT   (Arith_OUT),
        .Logic_OUT   (Logic_OUT),
        .CMP_OUT     (CMP_OUT),
        .Shift_OUT   (Shift_OUT),
        .Arith_Flag  (Arith_Flag),
        .Logic_Flag  (Logic_Flag),
        .CMP_Flag    (CMP_Flag),
        .Shift_Flag  (Shift_Flag),
        .Res_Valid   (Res_Valid),
        .Res_Ready   (Res_Ready),
        .Res_Data    (Res_Data),
        .Res_Unit    (Res_Unit),
        .Res_Err     (Res_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign en_vec = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

    // Unit models: combinational result, flag rising one edge after enable.
    always_comb begin
        Arith_OUT = (ALU_FUN == 2'b00) ? (A + B) : (A - B);
        case (ALU_FUN)
            2'b00:   Logic_OUT = A & B;
            2'b01:   Logic_OUT = A | B;
            2'b10:   Logic_OUT = A ^ B;
            default: Logic_OUT = ~(A | B);
        endcase
        CMP_OUT = (A > B) ? 16'd1 : 16'd0;
        case (ALU_FUN)
            2'b00:   Shift_OUT = A << 1;
            2'b01:   Shift_OUT = A >> 1;
            default: Shift_OUT = A;
        endcase
    end

    always @(posedge CLK or negedge rst) begin
        if (!rst) fl_q <= 4'b0000;
        else      fl_q <= en_vec;
    end

    assign Arith_Flag = auto_flag[0] ? fl_q[0] : force_flag[0];
    assign Logic_Flag = auto_flag[1] ? fl_q[1] : force_flag[1];
    assign CMP_Flag   = auto_flag[2] ? fl_q[2] : force_flag[2];
    assign Shift_Flag = auto_flag[3] ? fl_q[3] : force_flag[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        Cmd_Op    = op;
        Cmd_A     = a;
        Cmd_B     = b;
        Cmd_Valid = 1'b1;
        tick();
        Cmd_Valid = 1'b0;
    endtask

    // edges: clock edges after the accept edge until Res_Valid (-1 on bound expiry)
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int edges, output int en_cnt, output logic stable);
        send(op, a, b);
        edges  = 0;
        en_cnt = 0;
        stable = 1'b1;
        while (!Res_Valid && edges < 300) begin
            if (en_vec != 4'b0000) en_cnt++;
            if (ALU_FUN !== op[1:0] || A !== a || B !== b) stable = 1'b0;
            tick();
            edges++;
        end
        if (!Res_Valid) edges = -1;
    endtask

    task automatic release_res();
        Res_Ready = 1'b1;
        tick();
        Res_Ready = 1'b0;
    endtask

    int   edges, en_cnt;
    logic stable;
    logic seen;

    initial begin
        rst        = 1'b0;
        Cmd_Valid  = 1'b0;
        Cmd_Op     = 4'h0;
        Cmd_A      = 16'h0;
        Cmd_B      = 16'h0;
        Res_Ready  = 1'b0;
        auto_flag  = 4'b1111;
        force_flag = 4'b0000;

        #1;
        check("rst_cmd_ready", 32'(Cmd_Ready), 32'd0);
        check("rst_res_valid", 32'(Res_Valid), 32'd0);
        check("rst_enables",   32'(en_vec),    32'd0);
        check("rst_a",         32'(A),         32'd0);
        check("rst_res_data",  32'(Res_Data),  32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("idle_cmd_ready", 32'(Cmd_Ready), 32'd1);

        // Logic AND
        do_cmd(4'b0100, 16'h00FF, 16'h0F0F, edges, en_cnt, stable);
        check("and_latency", 32'(edges),    32'd2);
        check("and_data",    32'(Res_Data), 32'h000F);
        check("and_unit",    32'(Res_Unit), 32'd1);
        check("and_err",     32'(Res_Err),  32'd0);
        check("and_en_clr",  32'(en_vec),   32'd0);
        check("and_a_keep",  32'(A),        32'h00FF);
        check("and_b_keep",  32'(B),        32'h0F0F);
        release_res();
        check("and_done_valid", 32'(Res_Valid), 32'd0);
        check("and_done_ready", 32'(Cmd_Ready), 32'd1);

        // Logic NOR
        do_cmd(4'b0111, 16'h0000, 16'h0000, edges, en_cnt, stable);
        check("nor_latency", 32'(edges),    32'd2);
        check("nor_data",    32'(Res_Data), 32'hFFFF);
        check("nor_en_cyc",  32'(en_cnt),   32'd2);
        check("nor_stable",  32'(stable),   32'd1);
        check("nor_fun",     32'(ALU_FUN),  32'd3);
        release_res();

        // Shift right, then backpressure with an ignored command
        do_cmd(4'b1101, 16'h8000, 16'h0000, edges, en_cnt, stable);
        check("shr_latency", 32'(edges),    32'd2);
        check("shr_data",    32'(Res_Data), 32'h4000);
        check("shr_unit",    32'(Res_Unit), 32'd3);
        Cmd_Op    = 4'b0000;
        Cmd_A     = 16'h1234;
        Cmd_B     = 16'h1111;
        Cmd_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(Res_Valid), 32'd1);
            check("bp_data",  32'(Res_Data),  32'h4000);
            check("bp_ready", 32'(Cmd_Ready), 32'd0);
            check("bp_en",    32'(en_vec),    32'd0);
        end
        Cmd_Valid = 1'b0;
        release_res();
        check("bp_done_valid", 32'(Res_Valid), 32'd0);
        check("bp_done_ready", 32'(Cmd_Ready), 32'd1);
        check("bp_no_cmd_en",  32'(en_vec),    32'd0);
        check("bp_a_keep",     32'(A),         32'h8000);

        // Timeout on CMP with flag tied low
        auto_flag[2]  = 1'b0;
        force_flag[2] = 1'b0;
        do_cmd(4'b1000, 16'd5, 16'd3, edges, en_cnt, stable);
        check("to_latency", 32'(edges),      32'd8);
        check("to_en_cyc",  32'(en_cnt),     32'd8);
        check("to_data",    32'(Res_Data),   32'd0);
        check("to_err",     32'(Res_Err),    32'd1);
        check("to_cmp_en",  32'(CMP_Enable), 32'd0);
        release_res();

        // Flag arrives on the last WAIT cycle: flag wins
        send(4'b1000, 16'd5, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (Res_Valid) seen = 1'b1;
        end
        check("tie_early_valid", 32'(seen), 32'd0);
        force_flag[2] = 1'b1;
        tick();
        force_flag[2] = 1'b0;
        check("tie_valid", 32'(Res_Valid), 32'd1);
        check("tie_err",   32'(Res_Err),   32'd0);
        check("tie_data",  32'(Res_Data),  32'd1);
        release_res();
        auto_flag[2] = 1'b1;

        // Cross-unit isolation
        auto_flag[0]  = 1'b0;
        auto_flag[1]  = 1'b0;
        force_flag[0] = 1'b0;
        force_flag[1] = 1'b1;
        send(4'b0001, 16'h0010, 16'h0003);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Res_Valid) seen = 1'b1;
        end
        check("iso_no_result", 32'(seen),         32'd0);
        check("iso_arith_en",  32'(Arith_Enable), 32'd1);
        force_flag[0] = 1'b1;
        tick();
        force_flag = 4'b0000;
        check("iso_valid", 32'(Res_Valid), 32'd1);
        check("iso_data",  32'(Res_Data),  32'h000D);
        check("iso_unit",  32'(Res_Unit),  32'd0);
        check("iso_err",   32'(Res_Err),   32'd0);
        release_res();
        auto_flag = 4'b1111;

        // Reset in the middle of WAIT
        send(4'b0100, 16'h00FF, 16'h0F0F);
        check("mr_en_before", 32'(Logic_Enable), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("mr_en",    32'(en_vec),    32'd0);
        check("mr_valid", 32'(Res_Valid), 32'd0);
        check("mr_ready", 32'(Cmd_Ready), 32'd0);
        check("mr_a",     32'(A),         32'd0);
        check("mr_fun",   32'(ALU_FUN),   32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("mr_ready_after", 32'(Cmd_Ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Res_Valid || en_vec != 4'b0000) seen = 1'b1;
        end
        check("mr_no_resp", 32'(seen), 32'd0);
        do_cmd(4'b0000, 16'h0100, 16'h0023, edges, en_cnt, stable);
        check("mr_next_latency", 32'(edges),    32'd2);
        check("mr_next_data",    32'(Res_Data), 32'h0123);
        release_res();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
